// File: rtl/host_frame_receiver.sv
// Host link frame assembler: SYNC, control, 32-bit little-endian data word, and a checksum byte
// when HOST_RX_CHECKSUM_EN is defined. Frames are handed over on a dataReceived/clearDR handshake.
module host_frame_receiver #(
  parameter int unsigned     TO_W           = 24,
  parameter logic [7:0]      SYNC_BYTE      = 8'hA5,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd100000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        clearDR,
  input  logic        errClear,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  output logic        overrun,
  output logic [7:0]  errorCount,
  output logic        busy
);

  typedef enum logic [2:0] {
    StHunt, StCtrl, StD0, StD1, StD2, StD3, StChk, StCommit
  } state_e;

  localparam logic [TO_W-1:0] ToLast = TIMEOUT_CYCLES - 1'b1;

  state_e            state_q;
  logic [7:0]        sh_ctrl_q;
  logic [31:0]       sh_data_q;
  logic [TO_W-1:0]   to_q;
  logic              slot_free;
  logic              expire;
  logic              err_inc;
  logic              ov_set;
  logic [7:0]        chk_calc;

  assign slot_free = !dataReceived && !clearDR;
  assign chk_calc  = sh_ctrl_q ^ sh_data_q[7:0] ^ sh_data_q[15:8] ^ sh_data_q[23:16]
                   ^ sh_data_q[31:24];
  // A byte on the expiry cycle wins over the timeout.
  assign expire    = (state_q != StHunt) && (state_q != StCommit) && !rxValid && (to_q == ToLast);
  assign busy      = (state_q != StHunt);

  always_comb begin
    err_inc = 1'b0;
    ov_set  = 1'b0;
    if (state_q == StCommit && !slot_free) begin
      err_inc = 1'b1;
      ov_set  = 1'b1;
    end
    if (expire) err_inc = 1'b1;
`ifdef HOST_RX_CHECKSUM_EN
    if (state_q == StChk && rxValid && rxByte != chk_calc) err_inc = 1'b1;
`endif
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state_q      <= StHunt;
      sh_ctrl_q    <= 8'h00;
      sh_data_q    <= 32'h0;
      to_q         <= '0;
      dataReceived <= 1'b0;
      control      <= 8'h00;
      inputData    <= 32'h0;
      overrun      <= 1'b0;
      errorCount   <= 8'h00;
    end else begin
      if (dataReceived && clearDR) dataReceived <= 1'b0;

      case (state_q)
        StHunt: begin
          to_q <= '0;
          if (rxValid && rxByte == SYNC_BYTE) state_q <= StCtrl;
        end
        StCommit: begin
          to_q    <= '0;
          state_q <= StHunt;
          if (slot_free) begin
            dataReceived <= 1'b1;
            control      <= sh_ctrl_q;
            inputData    <= sh_data_q;
          end
        end
        default: begin
          if (rxValid) begin
            to_q <= '0;
            case (state_q)
              StCtrl: begin sh_ctrl_q <= rxByte;        state_q <= StD0; end
              StD0:   begin sh_data_q[7:0]   <= rxByte; state_q <= StD1; end
              StD1:   begin sh_data_q[15:8]  <= rxByte; state_q <= StD2; end
              StD2:   begin sh_data_q[23:16] <= rxByte; state_q <= StD3; end
              StD3: begin
                sh_data_q[31:24] <= rxByte;
`ifdef HOST_RX_CHECKSUM_EN
                state_q <= StChk;
`else
                state_q <= StCommit;
`endif
              end
              StChk:   state_q <= (rxByte == chk_calc) ? StCommit : StHunt;
              default: state_q <= StHunt;
            endcase
          end else if (expire) begin
            to_q    <= '0;
            state_q <= StHunt;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
      endcase

      // errClear beats any same-cycle event.
      if (errClear) begin
        overrun    <= 1'b0;
        errorCount <= 8'h00;
      end else begin
        if (ov_set) overrun <= 1'b1;
        if (err_inc && errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_host_frame_receiver.sv
// Bench for host_frame_receiver: vector table, directed corner sequences and a randomized
// byte stream compared every cycle against a queue-based frame model.
`timescale 1ns/1ps
module tb_host_frame_receiver;

  localparam int TO = 40;
`ifdef HOST_RX_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxv = 1'b0;
  logic [7:0]  rxb = 8'h00;
  logic        clr = 1'b0;
  logic        ec = 1'b0;
  logic        dr, ov, bsy;
  logic [7:0]  ctrl, errc;
  logic [31:0] data;

  host_frame_receiver #(
    .TO_W(24),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(24'(TO))
  ) dut (
    .masterClock(clk),
    .reset(rst_n),
    .rxValid(rxv),
    .rxByte(rxb),
    .clearDR(clr),
    .errClear(ec),
    .dataReceived(dr),
    .control(ctrl),
    .inputData(data),
    .overrun(ov),
    .errorCount(errc),
    .busy(bsy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: bytes of the frame collected so far, idle edges since the last byte.
  logic [7:0]  mq[$];
  int          m_idle;
  bit          m_commit;
  logic        m_dr, m_ov;
  logic [7:0]  m_ctrl, m_err, m_sh_ctrl;
  logic [31:0] m_data, m_sh_data;
  bit          clr_hold;

  task automatic model_reset();
    mq.delete();
    m_idle = 0; m_commit = 0; m_dr = 0; m_ov = 0;
    m_ctrl = 0; m_err = 0; m_sh_ctrl = 0; m_data = 0; m_sh_data = 0;
  endtask

  task automatic model_step();
    bit   inc, ovs, ok;
    logic old_dr;
    inc = 0; ovs = 0; ok = 0;
    old_dr = m_dr;
    if (old_dr && clr) m_dr = 0;
    if (m_commit) begin
      m_commit = 0;
      if (!old_dr && !clr) begin
        m_dr = 1; m_ctrl = m_sh_ctrl; m_data = m_sh_data;
      end else begin
        inc = 1; ovs = 1;
      end
    end else if (mq.size() == 0) begin
      m_idle = 0;
      if (rxv && rxb == 8'hA5) mq.push_back(rxb);
    end else if (rxv) begin
      mq.push_back(rxb);
      m_idle = 0;
      if (mq.size() == FLEN) begin
`ifdef HOST_RX_CHECKSUM_EN
        ok = (mq[6] == (mq[1] ^ mq[2] ^ mq[3] ^ mq[4] ^ mq[5]));
`else
        ok = 1;
`endif
        if (ok) begin
          m_commit = 1; m_sh_ctrl = mq[1]; m_sh_data = {mq[5], mq[4], mq[3], mq[2]};
        end else begin
          inc = 1;
        end
        mq.delete();
      end
    end else if (m_idle == TO - 1) begin
      mq.delete(); m_idle = 0; inc = 1;
    end else begin
      m_idle++;
    end
    if (ec) begin
      m_ov = 0; m_err = 0;
    end else begin
      if (ovs) m_ov = 1;
      if (inc && m_err != 8'hFF) m_err++;
    end
  endtask

  task automatic cmp_model();
    logic [50:0] got, exp;
    got = {dr, ctrl, data, ov, errc, bsy};
    exp = {m_dr, m_ctrl, m_data, m_ov, m_err, (mq.size() != 0) || m_commit};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model_cycle t=%0t got={dr,ctrl,data,ov,err,busy}=%h want=%h", $time, got, exp);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] b, input logic c, input logic e);
    rxv = v; rxb = b; clr = c; ec = e;
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  function automatic bq_t mk_frame(input logic [7:0] c, input logic [31:0] d);
    bq_t q;
    q.push_back(8'hA5); q.push_back(c);
    q.push_back(d[7:0]); q.push_back(d[15:8]); q.push_back(d[23:16]); q.push_back(d[31:24]);
`ifdef HOST_RX_CHECKSUM_EN
    q.push_back(c ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
`endif
    return q;
  endfunction

  task automatic send_bytes(input bq_t q, input logic c);
    for (int i = 0; i < q.size(); i++) begin
      tick(1'b1, q[i], c, 1'b0);
      tick(1'b0, 8'h00, c, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] c8, input logic [31:0] d, input logic c);
    send_bytes(mk_frame(c8, d), c);
  endtask

  task automatic ack();
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Consumer that acknowledges at a random moment and holds clearDR until dataReceived drops.
  task automatic rtick(input logic v, input logic [7:0] b);
    if (!clr_hold && m_dr && $urandom_range(0, 2) == 0) clr_hold = 1;
    else if (clr_hold && !m_dr) clr_hold = 0;
    tick(v, b, clr_hold, $urandom_range(0, 199) == 0);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        c;
    logic        dr;
    logic [7:0]  ctl;
    logic [31:0] dat;
    logic        dchk;
    logic        bsy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] b, input logic c, input logic xdr,
                     input logic [7:0] xctl, input logic [31:0] xdat, input logic dchk,
                     input logic xbsy);
    vec_t r;
    r.v = v; r.b = b; r.c = c; r.dr = xdr; r.ctl = xctl; r.dat = xdat; r.dchk = dchk;
    r.bsy = xbsy;
    tbl.push_back(r);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t q;
    int  kind, gap, n;

    // Frame A: A5 01 78 56 34 12 (+09), one idle cycle between bytes.
    add(1, 8'hA5, 0, 0, 0, 0, 0, 1);  add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(1, 8'h01, 0, 0, 0, 0, 0, 1);  add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(1, 8'h78, 0, 0, 0, 0, 0, 1);  add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(1, 8'h56, 0, 0, 0, 0, 0, 1);  add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(1, 8'h34, 0, 0, 0, 0, 0, 1);  add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(1, 8'h12, 0, 0, 0, 0, 0, 1);
`ifdef HOST_RX_CHECKSUM_EN
    add(0, 8'h00, 0, 0, 0, 0, 0, 1);  add(1, 8'h09, 0, 0, 0, 0, 0, 1);
`endif
    add(0, 8'h00, 0, 1, 8'h01, 32'h12345678, 1, 0);
    add(0, 8'h00, 0, 1, 8'h01, 32'h12345678, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0);

    model_reset();
    clr_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {7'h0, dr, ctrl, ov, errc, bsy}, 32'h0);
    check("reset_data", data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].v, tbl[i].b, tbl[i].c, 1'b0);
      check("tbl_dr", dr, tbl[i].dr);
      check("tbl_busy", bsy, tbl[i].bsy);
      if (tbl[i].dchk) begin
        check("tbl_ctrl", ctrl, tbl[i].ctl);
        check("tbl_data", data, tbl[i].dat);
      end
    end

    // Leading garbage ignored without error.
    send_bytes('{8'h00}, 1'b0);
    check("garbage_busy", bsy, 0);
    send_bytes('{8'hFF}, 1'b0);
    check("garbage_busy2", bsy, 0);
    send_frame(8'h02, 32'h0, 1'b0);
    check("sync_dr", dr, 1);
    check("sync_ctrl", ctrl, 8'h02);
    check("sync_data", data, 32'h0);
    check("sync_err", errc, 0);
    ack();

    // Inter-byte timeout, then recovery.
    send_bytes('{8'hA5, 8'h03}, 1'b0);
    repeat (TO + 3) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("to_busy", bsy, 0);
    check("to_err", errc, 1);
    check("to_dr", dr, 0);
    send_frame(8'h04, 32'hCAFEF00D, 1'b0);
    check("to_next_dr", dr, 1);
    check("to_next_data", data, 32'hCAFEF00D);
    ack();

    // Overrun while the first frame is unacknowledged, then errClear.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(8'h11, 32'hAABBCCDD, 1'b0);
    send_frame(8'h22, 32'h01020304, 1'b0);
    check("ovr_flag", ov, 1);
    check("ovr_err", errc, 1);
    check("ovr_ctrl", ctrl, 8'h11);
    check("ovr_data", data, 32'hAABBCCDD);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_flag", ov, 0);
    check("clr_err", errc, 0);
    ack();

`ifdef HOST_RX_CHECKSUM_EN
    q = mk_frame(8'h01, 32'h12345678);
    q[6] = 8'h00;
    send_bytes(q, 1'b0);
    check("chk_dr", dr, 0);
    check("chk_err", errc, 1);
`endif

    // Reset mid-frame with a frame still pending.
    send_frame(8'h33, 32'h55667788, 1'b0);
    send_bytes('{8'hA5, 8'h01, 8'h78}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {7'h0, dr, ctrl, ov, errc, bsy}, 32'h0);
    check("rst_mid_data", data, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h01, 32'h12345678, 1'b0);
    check("post_rst_ctrl", ctrl, 8'h01);
    check("post_rst_data", data, 32'h12345678);
    ack();

    // Randomized stream.
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      q = mk_frame(8'($urandom), $urandom);
      if (kind == 0) begin
        q.delete();
        q.push_back(8'($urandom));
      end else if (kind == 1) begin
        n = $urandom_range(1, FLEN - 1);
        while (q.size() > n) void'(q.pop_back());
      end else if (kind == 2) begin
        q[FLEN-1] = q[FLEN-1] ^ 8'h5A;
      end
      for (int i = 0; i < q.size(); i++) begin
        rtick(1'b1, q[i]);
        gap = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
        repeat (gap) rtick(1'b0, 8'h00);
      end
      if (kind == 1) repeat (TO + 2) rtick(1'b0, 8'h00);
    end

    // Saturation of errorCount through repeated overruns.
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int f = 0; f < 260; f++) send_frame(8'(f), 32'(f), 1'b0);
    check("sat_err", errc, 8'hFF);
    check("sat_ov", ov, 1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("sat_clear", errc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
